// File: rtl/serial_adder_pkg.sv
// Shared definitions for the digit-serial adder: FSM state encoding and a
// constant ceil(log2) helper used to size the digit counter.
package serial_adder_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        DONE = 2'd2
    } state_e;

    // Returns ceil(log2(value)); 0 for value <= 1.
    function automatic int clog2(input int value);
        int r;
        r = 0;
        for (int i = 0; i < 31; i++) begin
            if ((1 << i) < value) begin
                r = i + 1;
            end
        end
        return r;
    endfunction

endpackage

// File: rtl/serial_adder_seq_full_adder_cell.sv
// One-bit full adder cell built from two half adders and an OR gate;
// chained DIGIT times to form the per-cycle digit adder.
module full_adder_cell (
    input  logic a_i,
    input  logic b_i,
    input  logic cin_i,
    output logic sum_o,
    output logic cout_o
);

    logic ha0_sum;
    logic ha0_cry;
    logic ha1_cry;

    assign ha0_sum = a_i ^ b_i;
    assign ha0_cry = a_i & b_i;
    assign sum_o   = ha0_sum ^ cin_i;
    assign ha1_cry = ha0_sum & cin_i;
    assign cout_o  = ha0_cry | ha1_cry;

endmodule

// File: rtl/serial_adder_seq.sv
// Digit-serial adder: adds two WIDTH-bit operands DIGIT bits per clock with a
// start/busy/done handshake. Define SERIAL_ADDER_SUB_EN to add a SUB port (A-B).
module serial_adder_seq
    import serial_adder_pkg::*;
#(
    parameter int WIDTH = 8,
    parameter int DIGIT = 1
) (
    input  logic             clk_i,
    input  logic             rst_i,
    input  logic             start_i,
    input  logic [WIDTH-1:0] a_i,
    input  logic [WIDTH-1:0] b_i,
    input  logic             cin_i,
`ifdef SERIAL_ADDER_SUB_EN
    input  logic             sub_i,
`endif
    output logic             busy_o,
    output logic             done_o,
    output logic [WIDTH-1:0] sum_o,
    output logic             cout_o
);

    localparam int N     = WIDTH / DIGIT;
    localparam int CNT_W = (clog2(N) < 1) ? 1 : clog2(N);

    if (WIDTH < 1 || DIGIT < 1 || (WIDTH % DIGIT) != 0) begin : g_bad_param
        $error("serial_adder_seq: WIDTH must be >= 1 and a multiple of DIGIT");
    end

    logic sub_w;
`ifdef SERIAL_ADDER_SUB_EN
    assign sub_w = sub_i;
`else
    assign sub_w = 1'b0;
`endif

    state_e             state_q, state_d;
    logic [WIDTH-1:0]   a_q, a_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [WIDTH-1:0]   res_q, res_d;
    logic [WIDTH-1:0]   sum_q, sum_d;
    logic               carry_q, carry_d;
    logic               cout_q, cout_d;
    logic [CNT_W-1:0]   cnt_q, cnt_d;

    logic [DIGIT-1:0]   dsum_w;
    logic [DIGIT:0]     dcry_w;
    logic [WIDTH-1:0]   res_shift_w;

    // Ripple chain over the low DIGIT bits of the operand shift registers.
    assign dcry_w[0] = carry_q;
    for (genvar g = 0; g < DIGIT; g++) begin : g_fa
        full_adder_cell u_fa (
            .a_i    (a_q[g]),
            .b_i    (b_q[g]),
            .cin_i  (dcry_w[g]),
            .sum_o  (dsum_w[g]),
            .cout_o (dcry_w[g+1])
        );
    end

    // New digit enters at the MSB end; after N shifts the result is aligned.
    assign res_shift_w = WIDTH'({dsum_w, res_q} >> DIGIT);

    always_ff @(posedge clk_i or posedge rst_i) begin
        if (rst_i) begin
            state_q <= IDLE;
            a_q     <= '0;
            b_q     <= '0;
            res_q   <= '0;
            sum_q   <= '0;
            carry_q <= 1'b0;
            cout_q  <= 1'b0;
            cnt_q   <= '0;
        end else begin
            state_q <= state_d;
            a_q     <= a_d;
            b_q     <= b_d;
            res_q   <= res_d;
            sum_q   <= sum_d;
            carry_q <= carry_d;
            cout_q  <= cout_d;
            cnt_q   <= cnt_d;
        end
    end

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        res_d   = res_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        cout_d  = cout_q;
        cnt_d   = cnt_q;

        case (state_q)
            IDLE, DONE: begin
                if (start_i) begin
                    // Subtraction is A + ~B + 1, so SUB overrides the carry-in.
                    a_d     = a_i;
                    b_d     = sub_w ? ~b_i : b_i;
                    carry_d = sub_w ? 1'b1 : cin_i;
                    cnt_d   = '0;
                    state_d = RUN;
                end else begin
                    state_d = IDLE;
                end
            end
            RUN: begin
                a_d     = a_q >> DIGIT;
                b_d     = b_q >> DIGIT;
                carry_d = dcry_w[DIGIT];
                res_d   = res_shift_w;
                cnt_d   = cnt_q + CNT_W'(1);
                if (cnt_q == CNT_W'(N - 1)) begin
                    sum_d   = res_shift_w;
                    cout_d  = dcry_w[DIGIT];
                    state_d = DONE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    assign busy_o = (state_q == RUN);
    assign done_o = (state_q == DONE);
    assign sum_o  = sum_q;
    assign cout_o = cout_q;

endmodule

// File: tb/tb_serial_adder_seq.sv
// Directed bench for serial_adder_seq: an 8x1 and an 8x4 instance share the
// operand inputs; vector table plus hand-written handshake and reset sequences.
module tb_serial_adder_seq;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       start1 = 1'b0;
    logic       start4 = 1'b0;
    logic [7:0] a = '0;
    logic [7:0] b = '0;
    logic       cin = 1'b0;
`ifdef SERIAL_ADDER_SUB_EN
    logic       sub = 1'b0;
`endif

    logic       busy1, done1, cout1;
    logic [7:0] sum1;
    logic       busy4, done4, cout4;
    logic [7:0] sum4;

    int n_cmp = 0;
    int n_err = 0;

    always #5 clk = ~clk;

    serial_adder_seq #(.WIDTH(8), .DIGIT(1)) dut1 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start1),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy1),
        .done_o  (done1),
        .sum_o   (sum1),
        .cout_o  (cout1)
    );

    serial_adder_seq #(.WIDTH(8), .DIGIT(4)) dut4 (
        .clk_i   (clk),
        .rst_i   (rst),
        .start_i (start4),
        .a_i     (a),
        .b_i     (b),
        .cin_i   (cin),
`ifdef SERIAL_ADDER_SUB_EN
        .sub_i   (sub),
`endif
        .busy_o  (busy4),
        .done_o  (done4),
        .sum_o   (sum4),
        .cout_o  (cout4)
    );

    typedef struct {
        logic [7:0] a;
        logic [7:0] b;
        logic       cin;
        logic [7:0] sum;
        logic       cout;
    } vec_t;

    vec_t vecs [8];

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_cmp++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h, expected %0h", name, act, exp);
        end
    endtask

    // Runs one operation on the selected instance and checks latency, busy and result.
    task automatic do_op(input bit sel4, input logic [7:0] av, input logic [7:0] bv,
                         input logic cv, input logic subv,
                         input logic [7:0] exp_s, input logic exp_c, input string tag);
        int  n;
        int  lat;
        bit  busy_bad;
        n = sel4 ? 2 : 8;
        @(negedge clk);
        a = av; b = bv; cin = cv;
`ifdef SERIAL_ADDER_SUB_EN
        sub = subv;
`else
        if (subv) $display("note: %s requests SUB without SERIAL_ADDER_SUB_EN", tag);
`endif
        if (sel4) start4 = 1'b1; else start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0; start4 = 1'b0;
        check({tag, "_busy_start"}, sel4 ? busy4 : busy1, 1);
        lat = 0;
        busy_bad = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (sel4 ? done4 : done1) break;
            if (!(sel4 ? busy4 : busy1)) busy_bad = 1;
        end
        check({tag, "_latency"}, lat, n);
        check({tag, "_busy_run"}, busy_bad, 0);
        check({tag, "_sum"}, sel4 ? sum4 : sum1, exp_s);
        check({tag, "_cout"}, sel4 ? cout4 : cout1, exp_c);
    endtask

    initial begin
        int  lat;
        bit  seen_done;

        vecs[0] = '{8'h0F, 8'h01, 1'b0, 8'h10, 1'b0};
        vecs[1] = '{8'hFF, 8'h01, 1'b0, 8'h00, 1'b1};
        vecs[2] = '{8'hFF, 8'hFF, 1'b1, 8'hFF, 1'b1};
        vecs[3] = '{8'h9C, 8'h6B, 1'b0, 8'h07, 1'b1};
        vecs[4] = '{8'h22, 8'h11, 1'b0, 8'h33, 1'b0};
        vecs[5] = '{8'h80, 8'h80, 1'b0, 8'h00, 1'b1};
        vecs[6] = '{8'h00, 8'h00, 1'b1, 8'h01, 1'b0};
        vecs[7] = '{8'hA5, 8'h5A, 1'b1, 8'h00, 1'b1};

        // Reset state
        repeat (2) @(posedge clk);
        #1;
        check("rst_busy1", busy1, 0);
        check("rst_done1", done1, 0);
        check("rst_sum1",  sum1, 0);
        check("rst_cout1", cout1, 0);
        check("rst_busy4", busy4, 0);
        check("rst_sum4",  sum4, 0);
        @(negedge clk);
        rst = 1'b0;

        // Vector table on both digit widths
        for (int i = 0; i < 8; i++) begin
            do_op(1'b0, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout, $sformatf("d1_v%0d", i));
            do_op(1'b1, vecs[i].a, vecs[i].b, vecs[i].cin, 1'b0, vecs[i].sum, vecs[i].cout, $sformatf("d4_v%0d", i));
        end

        // START during RUN is ignored; START in the DONE cycle is accepted
        do_op(1'b0, 8'h0F, 8'h01, 1'b0, 1'b0, 8'h10, 1'b0, "pre_t4");
        @(negedge clk);
        a = 8'h10; b = 8'h20; cin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        check("t4_sum_held", sum1, 8'h10);
        a = 8'hAA; b = 8'hAA; cin = 1'b1; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("t4_busy_ign", busy1, 1);
        check("t4_done_ign", done1, 0);
        lat = 4;
        for (int i = 0; i < 40; i++) begin
            if (done1) break;
            @(posedge clk); #1;
            lat++;
        end
        check("t4_latency1", lat, 8);
        check("t4_sum1", sum1, 8'h30);
        check("t4_cout1", cout1, 0);
        check("t4_done_cycle", done1, 1);
        a = 8'h01; b = 8'h02; cin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        check("t4_b2b_busy", busy1, 1);
        check("t4_b2b_done", done1, 0);
        check("t4_b2b_held", sum1, 8'h30);
        lat = 0;
        for (int i = 0; i < 40; i++) begin
            @(posedge clk); #1;
            lat++;
            if (done1) break;
        end
        check("t4_latency2", lat, 8);
        check("t4_sum2", sum1, 8'h03);

        // Asynchronous reset in the middle of RUN
        @(negedge clk);
        a = 8'h55; b = 8'h11; cin = 1'b0; start1 = 1'b1;
        @(posedge clk); #1;
        start1 = 1'b0;
        repeat (3) @(posedge clk);
        #2 rst = 1'b1;
        #1;
        check("t5_busy", busy1, 0);
        check("t5_done", done1, 0);
        check("t5_sum",  sum1, 0);
        check("t5_cout", cout1, 0);
        @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        seen_done = 0;
        for (int i = 0; i < 12; i++) begin
            @(posedge clk); #1;
            if (done1) seen_done = 1;
        end
        check("t5_no_done", seen_done, 0);
        check("t5_idle", busy1, 0);
        do_op(1'b0, 8'h22, 8'h11, 1'b0, 1'b0, 8'h33, 1'b0, "t5_after");

`ifdef SERIAL_ADDER_SUB_EN
        do_op(1'b0, 8'h05, 8'h07, 1'b0, 1'b1, 8'hFE, 1'b0, "t6_sub_borrow");
        do_op(1'b0, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, "t6_sub_ok");
        do_op(1'b1, 8'h07, 8'h05, 1'b0, 1'b1, 8'h02, 1'b1, "t6_sub_d4");
`endif

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
